// File: rtl/lab_chk_pkg.sv
// Shared types and constants for the lab response checker.
//   state_t    : checker FSM states
//   TRUTH_*    : ready-made 2-input truth tables, bit [vec] = expected output
package lab_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

endpackage

// File: rtl/lab_settle_det.sv
// Stability detector for the applied stimulus vector.
//   clk, rst : clock, synchronous active-high reset
//   vec_in   : vector currently driven into the DUT
//   vec_q    : vec_in registered every cycle (the value a sample must use)
//   chg      : vec_in differs from last cycle's value
//   stable   : vec_in has held for SETTLE_CYC consecutive cycles and is
//              still unchanged this cycle
module lab_settle_det #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] vec_in,
    output logic [N_IN-1:0] vec_q,
    output logic            chg,
    output logic            stable
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);

    logic [CW-1:0] cnt_q;

    assign chg = (vec_in != vec_q);
    // Also requiring no change this cycle guarantees vec_q still holds the
    // settled value throughout the following SAMPLE cycle.
    assign stable = (cnt_q == SETTLE_MAX) && !chg;

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            cnt_q <= '0;
        end else begin
            vec_q <= vec_in;
            if (chg)
                cnt_q <= '0;
            else if (cnt_q != SETTLE_MAX)
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/lab_resp_checker.sv
// Response checker for a small combinational lab DUT.
// Waits for each applied vector to settle, compares dut_out against TRUTH,
// tracks vector coverage and scores the run.
//   clk, rst      : clock, synchronous active-high reset
//   start         : 1-cycle pulse, starts a run from IDLE or DONE
//   vec_in        : stimulus vector applied to the DUT
//   dut_out       : DUT output
//   busy          : run in progress
//   done          : run finished, held until start/rst
//   pass          : while done: full coverage, no errors, no timeout
//   timeout       : while done: run aborted for lack of samples
//   err_cnt       : mismatching samples (saturating)
//   smp_cnt       : samples taken (saturating)
//   first_err_vld : a mismatch has been seen this run
//   first_err_vec : vector of the first mismatch
module lab_resp_checker
    import lab_chk_pkg::*;
#(
    parameter int                      N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH      = TRUTH_XOR,
    parameter int                      SETTLE_CYC = 3,
    parameter int                      TIMEOUT    = 1023,
    parameter int                      CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_IN-1:0]  vec_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic             first_err_vld,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int NV = 1 << N_IN;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q;
    logic            chg, stable;
    logic [NV-1:0]   bitmap_q, bitmap_nxt;
    logic [TW-1:0]   tcnt_q;
    logic            armed_q, tmo_q;
    logic            start_acc, do_sample, tmo_hit, mismatch;

    lab_settle_det #(
        .N_IN       (N_IN),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .vec_in (vec_in),
        .vec_q  (vec_q),
        .chg    (chg),
        .stable (stable)
    );

    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign timeout    = tmo_q;
    assign pass       = done && (&bitmap_q) && (err_cnt == '0) && !tmo_q;
    assign bitmap_nxt = bitmap_q | (NV'(1) << vec_q);
    assign mismatch   = dut_out ^ TRUTH[vec_q];
    assign tmo_hit    = busy && (tcnt_q == TMAX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        do_sample = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    start_acc = 1'b1;
                end
            end
            SETTLE: begin
                if (tmo_hit)
                    state_d = DONE;
                else if (stable && armed_q)
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                if (tmo_hit) begin
                    state_d = DONE;
                end else begin
                    do_sample = 1'b1;
                    state_d   = (&bitmap_nxt) ? DONE : SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoring, coverage and timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt       <= '0;
            smp_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            bitmap_q      <= '0;
            tcnt_q        <= '0;
            armed_q       <= 1'b0;
            tmo_q         <= 1'b0;
        end else if (start_acc) begin
            err_cnt       <= '0;
            smp_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            bitmap_q      <= '0;
            tcnt_q        <= '0;
            // The vector already on the bus deserves one sample in the new run.
            armed_q       <= 1'b1;
            tmo_q         <= 1'b0;
        end else begin
            if (do_sample)
                tcnt_q <= '0;
            else if (busy && tcnt_q != TMAX)
                tcnt_q <= tcnt_q + 1'b1;

            if (tmo_hit)
                tmo_q <= 1'b1;

            // A fresh vector re-arms sampling; a change during SAMPLE wins
            // over the disarm so the new vector is not lost.
            if (chg)
                armed_q <= 1'b1;
            else if (do_sample)
                armed_q <= 1'b0;

            if (do_sample) begin
                bitmap_q <= bitmap_nxt;
                if (smp_cnt != '1)
                    smp_cnt <= smp_cnt + 1'b1;
                if (mismatch) begin
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                    if (!first_err_vld) begin
                        first_err_vld <= 1'b1;
                        first_err_vec <= vec_q;
                    end
                end
            end
        end
    end

endmodule
